// File: rtl/cic_down_if.sv
// cic_down_if: sample-stream bundle; master drives clk_enable/filter_in, slave drives filter_out/ce_out
interface cic_down_if #(
  parameter int DW_IN = 16,
  parameter int DW_OUT = 12
);
  logic clk_enable;
  logic signed [DW_IN-1:0] filter_in;
  logic signed [DW_OUT-1:0] filter_out;
  logic ce_out;
  modport master (output clk_enable, filter_in, input filter_out, ce_out);
  modport slave (input clk_enable, filter_in, output filter_out, ce_out);
endinterface

// File: rtl/cic_down.sv
// cic_down: N-stage CIC decimator by R with rounding/saturating output; ports clk, reset, bus (slave: clk_enable/filter_in in, filter_out/ce_out out)
module cic_down #(
  parameter int DW_IN = 16,
  parameter int DW_OUT = 12,
  parameter int N = 3,
  parameter int R = 64
) (
  input logic clk,
  input logic reset,
  cic_down_if.slave bus
);
  localparam int LR = $clog2(R);
  localparam int DW_ACC = DW_IN + N * LR;
  localparam int S = DW_ACC - DW_OUT;
  logic signed [DW_ACC-1:0] integ [N];
  logic signed [DW_ACC-1:0] c [N];
  logic signed [DW_ACC-1:0] d [N];
  logic signed [DW_ACC-1:0] stage_in [N];
  logic signed [DW_ACC-1:0] comb_in, rnd;
  logic [LR-1:0] dec_cnt;
  logic [N+1:0] vld;
  logic ovf, unused_bits;
  always_comb begin
    stage_in[0] = comb_in;
    for (int k = 1; k < N; k++) stage_in[k] = c[k-1];
    rnd = c[N-1] + (DW_ACC'(1) << (S - 1));
    ovf = !c[N-1][DW_ACC-1] && rnd[DW_ACC-1];
  end
  assign unused_bits = ^rnd[S-1:0];
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < N; k++) begin
        integ[k] <= '0;
        c[k] <= '0;
        d[k] <= '0;
      end
      comb_in <= '0;
      dec_cnt <= '0;
      vld <= '0;
      bus.filter_out <= '0;
      bus.ce_out <= 1'b0;
    end else begin
      if (bus.clk_enable) begin
        dec_cnt <= dec_cnt + 1'b1;
        integ[0] <= integ[0] + DW_ACC'(bus.filter_in);
        for (int k = 1; k < N; k++) integ[k] <= integ[k] + integ[k-1];
      end
      vld <= {vld[N:0], bus.clk_enable && dec_cnt == LR'(R - 1)};
      if (vld[0]) comb_in <= integ[N-1];
      for (int k = 0; k < N; k++) begin
        if (vld[k+1]) begin
          c[k] <= stage_in[k] - d[k];
          d[k] <= stage_in[k];
        end
      end
      bus.ce_out <= vld[N+1];
      if (vld[N+1]) bus.filter_out <= ovf ? {1'b0, {(DW_OUT-1){1'b1}}} : rnd[DW_ACC-1 -: DW_OUT];
    end
  end
endmodule

// File: tb/tb_cic_down.sv
// tb_cic_down: scoreboard bench for cic_down against a boxcar-cubed convolution model
module tb_cic_down;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  cic_down_if #(.DW_IN(16), .DW_OUT(12)) bus ();
  cic_down dut (.clk(clk), .reset(reset), .bus(bus));
  typedef struct {longint val; longint due;} exp_t;
  exp_t q[$];
  exp_t e;
  longint xs[$];
  longint h[190];
  longint cyc = 0, last_out = 0, out_sum = 0, prev_ce = 0, ce_gap = 0;
  int n_out = 0, checks = 0, passes = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
  endtask
  function automatic longint model();
    longint y = 0;
    int n = xs.size() - 1;
    for (int k = 0; k < 190; k++) if (n - 2 - k >= 0) y += h[k] * xs[n-2-k];
    y = (y + (longint'(1) << 21)) >>> 22;
    return y > 2047 ? 2047 : (y < -2048 ? -2048 : y);
  endfunction
  task automatic step(input bit en, input longint v);
    bus.clk_enable = en;
    bus.filter_in = 16'(v);
    if (en) begin
      xs.push_back(v);
      if (xs.size() % 64 == 0) q.push_back('{model(), cyc + 6});
    end
    @(posedge clk);
    #1;
  endtask
  task automatic tick(input longint v, input int gap);
    step(1'b1, v);
    repeat (gap - 1) step(1'b0, 0);
  endtask
  task automatic drain();
    repeat (12) step(1'b0, 0);
    chk("pending", q.size(), 0);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    bus.clk_enable = 1'b0;
    q.delete();
    xs.delete();
    last_out = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_out", bus.filter_out, 0);
    chk("reset_ce", bus.ce_out, 0);
    n_out = 0;
    out_sum = 0;
  endtask
  task automatic run_dc(input longint v, input int ticks, input longint exp_last);
    do_reset();
    repeat (ticks) tick(v, 2);
    drain();
    chk("dc_value", last_out, exp_last);
  endtask
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.ce_out) begin
        chk("ce_expected", longint'(q.size() != 0), 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("out_value", bus.filter_out, e.val);
          chk("ce_time", cyc, e.due);
        end
        ce_gap = cyc - prev_ce;
        prev_ce = cyc;
        last_out = bus.filter_out;
        out_sum += last_out;
        n_out++;
      end else chk("held", bus.filter_out, last_out);
    end
  end
  initial begin
    bus.clk_enable = 1'b0;
    bus.filter_in = '0;
    foreach (h[k]) h[k] = 0;
    for (int a = 0; a < 64; a++)
      for (int b = 0; b < 64; b++)
        for (int c = 0; c < 64; c++) h[a+b+c]++;
    run_dc(16000, 640, 1000);
    chk("dc_count", n_out, 10);
    run_dc(32767, 256, 2047);
    run_dc(-32768, 256, -2048);
    run_dc(8, 256, 1);
    run_dc(24, 256, 2);
    run_dc(-8, 256, 0);
    run_dc(-24, 256, -1);
    do_reset();
    tick(32767, 2);
    repeat (383) tick(0, 2);
    drain();
    chk("impulse_count", n_out, 6);
    chk("impulse_sum_ok", longint'(out_sum >= 30 && out_sum <= 34), 1);
    chk("impulse_tail", last_out, 0);
    do_reset();
    repeat (64) tick(1000, 2);
    do_reset();
    repeat (64) tick(1000, 2);
    drain();
    chk("post_reset_count", n_out, 1);
    do_reset();
    for (int i = 0; i < 320; i++) tick(i % 2 ? -20000 : 20000, 2);
    drain();
    chk("nyquist_value", last_out, 0);
    chk("nyquist_gap", ce_gap, 128);
    do_reset();
    repeat (400) tick(longint'($urandom_range(0, 65535)) - 32768, int'($urandom_range(2, 4)));
    drain();
    chk("random_count", n_out, 6);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
